// File: rtl/asi_burst_seq.sv
// -----------------------------------------------------------------------------
// asi_burst_seq
//   Per-beat address / byte-lane sequencer for the AXI slave write and read
//   paths. Takes one decoded AW or AR command at a time and emits one beat
//   descriptor (address, legal lane mask, ID, last, error) per data transfer.
//   FIXED, INCR and WRAP bursts are supported. Illegal bursts still produce
//   len+1 beats so the datapath can drain W data or supply R beats, but they
//   carry bt_err=1, a held address and an all-zero lane mask.
//
// Handshakes: both channels use valid/ready. A transfer happens on the rising
//   edge where valid and ready are both high. A valid holds its payload stable
//   until it is taken. A valid never drops without a transfer, except on reset.
//
// Ports
//   ACLK, ARESET       clock, synchronous active-high reset
//   cmd_valid/ready    command channel handshake
//   cmd_id/addr/len/size/burst   decoded address-channel fields
//   bt_valid/ready     beat descriptor handshake
//   bt_addr/strb/id    beat address, legal byte lanes, transaction ID
//   bt_last            final beat of the burst
//   bt_err             burst is illegal (SLVERR, data dropped)
//   dbg_state          FSM state (0 = IDLE, 1 = BURST)
// -----------------------------------------------------------------------------
module asi_burst_seq #(
  parameter int AXI_AW = 40,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int AXI_IW = 8,
  parameter int AXI_DW = 128
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_IW-1:0]     cmd_id,
  input  logic [AXI_AW-1:0]     cmd_addr,
  input  logic [AXI_LW-1:0]     cmd_len,
  input  logic [AXI_SW-1:0]     cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  bt_valid,
  input  logic                  bt_ready,
  output logic [AXI_AW-1:0]     bt_addr,
  output logic [AXI_DW/8-1:0]   bt_strb,
  output logic [AXI_IW-1:0]     bt_id,
  output logic                  bt_last,
  output logic                  bt_err,
  output logic                  dbg_state
);

  localparam int SLV_BYTES = AXI_DW / 8;
  localparam int LANEW     = $clog2(SLV_BYTES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [AXI_AW-1:0] ONE      = AXI_AW'(1);
  localparam logic [LANEW:0]    LANE_ONE = (LANEW+1)'(1);
  localparam logic [AXI_SW-1:0] MAX_SIZE = AXI_SW'(LANEW);

  // Registered burst context
  logic [0:0]        state_q;
  logic [AXI_IW-1:0] id_q;
  logic [AXI_AW-1:0] addr_q;
  logic [AXI_AW-1:0] wrap_lo_q;
  logic [AXI_AW-1:0] wrap_hi_q;
  logic [AXI_LW-1:0] len_q;
  logic [AXI_LW-1:0] cnt_q;
  logic [AXI_SW-1:0] size_q;
  logic [1:0]        burst_q;
  logic              err_q;

  logic accept;
  logic advance;

  assign bt_valid  = (state_q == ST_BURST);
  assign bt_last   = bt_valid & (cnt_q == len_q);
  assign bt_err    = bt_valid & err_q;
  assign bt_addr   = addr_q;
  assign bt_id     = id_q;
  assign dbg_state = state_q[0];

  // A new command may be taken while idle, or on the edge that retires the
  // last beat of the current burst (back-to-back with no bubble).
  assign cmd_ready = ~ARESET & (~bt_valid | (bt_ready & bt_last));
  assign accept    = cmd_valid & cmd_ready;
  assign advance   = bt_valid & bt_ready & ~bt_last;

  // ---------------------------------------------------------------------------
  // Command decode: legality checks and WRAP window, evaluated on the
  // incoming fields so they can be latched at accept.
  // ---------------------------------------------------------------------------
  logic [AXI_AW-1:0] c_bytes;
  logic [AXI_AW-1:0] c_mask;
  logic [11:0]       c_al12;
  logic [19:0]       c_span;
  logic [AXI_SW-1:0] c_lenlog;
  logic              c_len_ok;
  logic [AXI_SW:0]   c_wlog;
  logic [AXI_AW-1:0] c_tot;
  logic [AXI_AW-1:0] c_wlo;
  logic [AXI_AW-1:0] c_whi;
  logic              c_err;

  always_comb begin
    c_bytes  = ONE << cmd_size;
    c_mask   = c_bytes - ONE;
    c_al12   = cmd_addr[11:0] & ~c_mask[11:0];
    // Bytes from the aligned start to the end of the burst within its 4 KB page
    c_span   = {8'd0, c_al12} + ((20'(cmd_len) + 20'd1) << cmd_size);

    c_lenlog = '0;
    c_len_ok = 1'b0;
    case (cmd_len)
      AXI_LW'(1):  begin c_lenlog = AXI_SW'(1); c_len_ok = 1'b1; end
      AXI_LW'(3):  begin c_lenlog = AXI_SW'(2); c_len_ok = 1'b1; end
      AXI_LW'(7):  begin c_lenlog = AXI_SW'(3); c_len_ok = 1'b1; end
      AXI_LW'(15): begin c_lenlog = AXI_SW'(4); c_len_ok = 1'b1; end
      default:     begin c_lenlog = '0;         c_len_ok = 1'b0; end
    endcase

    // WRAP window: total size T = B*(len+1) is a power of two for legal lengths
    c_wlog = {1'b0, cmd_size} + {1'b0, c_lenlog};
    c_tot  = ONE << c_wlog;
    c_wlo  = cmd_addr & ~(c_tot - ONE);
    c_whi  = c_wlo + c_tot;

    c_err = (cmd_burst == BURST_RSVD)
          | (cmd_size > MAX_SIZE)
          | ((cmd_burst == BURST_WRAP) & ~c_len_ok)
          | ((cmd_burst == BURST_WRAP) & (|(cmd_addr & c_mask)))
          | ((cmd_burst == BURST_INCR) & (c_span > 20'd4096));
  end

  // ---------------------------------------------------------------------------
  // Next beat address
  // ---------------------------------------------------------------------------
  logic [AXI_AW-1:0] beat_bytes;
  logic [AXI_AW-1:0] beat_mask;
  logic [AXI_AW-1:0] incr_addr;
  logic [AXI_AW-1:0] wrap_addr;
  logic [AXI_AW-1:0] next_addr;

  always_comb begin
    beat_bytes = ONE << size_q;
    beat_mask  = beat_bytes - ONE;
    // INCR realigns after beat 0, so an unaligned start only affects beat 0
    incr_addr  = (addr_q & ~beat_mask) + beat_bytes;
    wrap_addr  = addr_q + beat_bytes;
    if (wrap_addr == wrap_hi_q) begin
      wrap_addr = wrap_lo_q;
    end
    next_addr = addr_q;
    if (!err_q) begin
      case (burst_q)
        BURST_INCR: next_addr = incr_addr;
        BURST_WRAP: next_addr = wrap_addr;
        default:    next_addr = addr_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte lanes: from the beat address lane up to the end of its aligned
  // B-byte container on the bus.
  // ---------------------------------------------------------------------------
  logic [LANEW-1:0] lane_lo;
  logic [LANEW-1:0] lane_al;
  logic [LANEW:0]   lane_hi;
  logic [LANEW:0]   lane_idx;

  always_comb begin
    lane_lo  = addr_q[LANEW-1:0];
    lane_al  = lane_lo & ~beat_mask[LANEW-1:0];
    lane_hi  = {1'b0, lane_al} + beat_bytes[LANEW:0] - LANE_ONE;
    lane_idx = '0;
    bt_strb  = '0;
    for (int i = 0; i < SLV_BYTES; i++) begin
      lane_idx   = (LANEW+1)'(i);
      bt_strb[i] = bt_valid & ~err_q
                 & (lane_idx >= {1'b0, lane_lo})
                 & (lane_idx <= lane_hi);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      wrap_lo_q <= '0;
      wrap_hi_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      state_q   <= ST_BURST;
      id_q      <= cmd_id;
      addr_q    <= cmd_addr;
      wrap_lo_q <= c_wlo;
      wrap_hi_q <= c_whi;
      len_q     <= cmd_len;
      cnt_q     <= '0;
      size_q    <= cmd_size;
      burst_q   <= cmd_burst;
      err_q     <= c_err;
    end else if (advance) begin
      cnt_q  <= cnt_q + AXI_LW'(1);
      addr_q <= next_addr;
    end else if (bt_valid & bt_ready) begin
      // last beat taken with no follow-on command
      state_q <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_asi_burst_seq.sv
`timescale 1ns/1ps
module tb_asi_burst_seq;

  localparam int AW = 40;
  localparam int LW = 8;
  localparam int SW = 3;
  localparam int IW = 8;
  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam int DESC_W = AW + NB + IW + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [SW-1:0] cmd_size;
  logic [1:0]    cmd_burst;
  logic          bt_valid;
  logic          bt_ready;
  logic [AW-1:0] bt_addr;
  logic [NB-1:0] bt_strb;
  logic [IW-1:0] bt_id;
  logic          bt_last;
  logic          bt_err;
  logic          dbg_state;

  asi_burst_seq #(
    .AXI_AW(AW), .AXI_LW(LW), .AXI_SW(SW), .AXI_IW(IW), .AXI_DW(DW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst),
    .bt_valid(bt_valid), .bt_ready(bt_ready), .bt_addr(bt_addr),
    .bt_strb(bt_strb), .bt_id(bt_id), .bt_last(bt_last), .bt_err(bt_err),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [DESC_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rdy_mode = 1'b0;
  logic b2b_win = 1'b0;
  int hs_first = -1;
  int hs_last = -1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected descriptors for one command, from burst rules.
  task automatic model_push(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [SW-1:0] size,
                            input logic [1:0] burst);
    longint unsigned a, b, al, t, lo, ba, nbeats, off, alo;
    logic err;
    logic [NB-1:0] strb;
    a = addr;
    b = 64'd1 << size;
    al = a - (a % b);
    nbeats = len;
    nbeats = nbeats + 1;
    err = (burst == 2'd3) || (size > 3'd4) ||
          (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
          (burst == 2'd2 && (a % b) != 0) ||
          (burst == 2'd1 && ((al % 4096) + nbeats * b) > 4096);
    t = b * nbeats;
    lo = a - (a % t);
    for (longint unsigned n = 0; n < nbeats; n++) begin
      if (err || burst == 2'd0) ba = a;
      else if (burst == 2'd1) ba = (n == 0) ? a : al + n * b;
      else ba = lo + ((a - lo + n * b) % t);
      off = ba % NB;
      alo = off - (off % b);
      strb = '0;
      for (int k = 0; k < NB; k++)
        if (!err && k >= off && k < alo + b) strb[k] = 1'b1;
      exp_q.push_back({AW'(ba), strb, id, (n + 1 == nbeats), err});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, input logic [SW-1:0] size,
                          input logic [1:0] burst);
    int waited = 0;
    logic accepted = 1'b0;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    while (!accepted && waited < 2000) begin
      @(negedge ACLK);
      if (cmd_ready) begin
        model_push(id, addr, len, size, burst);
        accepted = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!accepted) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept_timeout: got no cmd_ready expected accept within 2000 cycles");
    end
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || bt_valid) && w < 5000) begin
      @(negedge ACLK);
      w++;
    end
    check("drain_leftover", 72'(exp_q.size()), 72'd0);
    @(posedge ACLK); #1;
  endtask

  // ---------------------------------------------------------------------------
  // bt_ready driver and cycle counter
  // ---------------------------------------------------------------------------
  initial begin
    bt_ready = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      bt_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops on every descriptor handshake, checks stall stability
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [DESC_W-1:0] cur, prev, exp;
    logic stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        stall_prev = 1'b0;
      end else begin
        cur = {bt_addr, bt_strb, bt_id, bt_last, bt_err};
        if (stall_prev) begin
          check("stall_valid", 72'(bt_valid), 72'd1);
          check("stall_hold", 72'(cur), 72'(prev));
        end
        if (bt_valid && !bt_ready) begin
          check("stall_cmd_ready", 72'(cmd_ready), 72'd0);
          prev = cur;
          stall_prev = 1'b1;
        end else begin
          stall_prev = 1'b0;
        end
        if (bt_valid && bt_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_beat: got %h expected none", cur);
          end else begin
            exp = exp_q.pop_front();
            check("beat", 72'(cur), 72'(exp));
          end
          if (b2b_win) begin
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [LW-1:0] wl[4];
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [SW-1:0] size;
    logic [1:0]    burst;
    int r, s, total;
    wl[0] = 8'd1; wl[1] = 8'd3; wl[2] = 8'd7; wl[3] = 8'd15;

    ARESET = 1'b1;
    cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0;
    @(posedge ACLK); @(posedge ACLK);
    @(negedge ACLK);
    check("rst_bt_valid", 72'(bt_valid), 72'd0);
    check("rst_bt_last",  72'(bt_last),  72'd0);
    check("rst_bt_err",   72'(bt_err),   72'd0);
    check("rst_bt_addr",  72'(bt_addr),  72'd0);
    check("rst_bt_strb",  72'(bt_strb),  72'd0);
    check("rst_bt_id",    72'(bt_id),    72'd0);
    check("rst_cmd_ready", 72'(cmd_ready), 72'd0);
    check("rst_state",    72'(dbg_state), 72'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Directed cases
    send_cmd(8'h11, 40'h1004, 8'd3, 3'd4, 2'd1);   // INCR
    send_cmd(8'h22, 40'h0038, 8'd3, 3'd3, 2'd2);   // WRAP
    send_cmd(8'h33, 40'h0102, 8'd2, 3'd2, 2'd0);   // FIXED
    send_cmd(8'h44, 40'h0FF0, 8'd1, 3'd4, 2'd1);   // INCR crossing 4 KB
    send_cmd(8'h55, 40'h0040, 8'd2, 3'd2, 2'd2);   // WRAP len 2
    send_cmd(8'h66, 40'h0200, 8'd0, 3'd2, 2'd3);   // reserved burst
    send_cmd(8'h77, 40'h0100, 8'd0, 3'd5, 2'd1);   // size too large
    send_cmd(8'h88, 40'h0FFF, 8'd0, 3'd0, 2'd1);   // single byte at page end
    drain();

    // Back-to-back, always ready: handshakes must be contiguous
    b2b_win = 1'b1;
    total = 0;
    for (int i = 0; i < 10; i++) begin
      len = LW'($urandom_range(0, 1));
      total += int'(len) + 1;
      send_cmd(IW'(i), {AW'($urandom) & ~40'h3}, len, 3'd2, 2'd1);
    end
    drain();
    b2b_win = 1'b0;
    check("b2b_no_bubble", 72'(hs_last - hs_first + 1), 72'(total));

    // Back-to-back with random stalls
    rdy_mode = 1'b1;
    for (int i = 0; i < 10; i++)
      send_cmd(IW'(i + 16), AW'($urandom), LW'($urandom_range(0, 1)),
               SW'($urandom_range(0, 4)), 2'd1);

    // Random mix
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      burst = (r < 2) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      s = $urandom_range(0, 11);
      size = (s >= 10) ? SW'(5 + $urandom_range(0, 2)) : SW'(s % 5);
      if (burst == 2'd2 && $urandom_range(0, 4) != 0) len = wl[$urandom_range(0, 3)];
      else if ($urandom_range(0, 19) == 0) len = LW'($urandom_range(16, 255));
      else len = LW'($urandom_range(0, 15));
      addr = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 2) == 0) addr[11:0] = 12'(4096 - 16 * $urandom_range(1, 8));
      if (burst == 2'd2 && $urandom_range(0, 3) != 0) addr = addr & ~((40'd1 << size) - 40'd1);
      send_cmd(IW'($urandom), addr, len, size, burst);
    end
    drain();

    // Reset on beat 2 of an INCR len-7 burst
    rdy_mode = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    send_cmd(8'h5A, 40'h2000, 8'd7, 3'd4, 2'd1);   // beat 0 now presented
    @(posedge ACLK); #1;                           // beat 1
    @(posedge ACLK); #1;                           // beat 2
    ARESET = 1'b1;
    @(negedge ACLK);
    check("rst_mid_cmd_ready", 72'(cmd_ready), 72'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("rst_mid_bt_valid", 72'(bt_valid), 72'd0);
    check("rst_mid_cmd_ready2", 72'(cmd_ready), 72'd0);
    exp_q.delete();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    send_cmd(8'hA5, 40'h3008, 8'd2, 3'd3, 2'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
